// File: rtl/izh_step_scheduler_pkg.sv
// izh_pkg: fixed-point type, FSM states and arithmetic helpers shared by the
// Izhikevich step scheduler and its update unit.
// Build option: IZH_SAT_EN selects saturating arithmetic; otherwise all
// results wrap modulo 2^18.
package izh_pkg;

    typedef logic signed [17:0] fix_t;
    typedef logic signed [23:0] wide_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CALC,
        S_WRITE,
        S_DONE
    } state_t;

    localparam fix_t FIX_MAX = 18'sh1_FFFF;
    localparam fix_t FIX_MIN = 18'sh2_0000;

    // Bring a wide intermediate back into 2.16 range (clip or wrap).
    function automatic fix_t fit_fix(input wide_t x);
`ifdef IZH_SAT_EN
        if (x > wide_t'(FIX_MAX)) return FIX_MAX;
        if (x < wide_t'(FIX_MIN)) return FIX_MIN;
        return fix_t'(x);
`else
        return fix_t'(x);
`endif
    endfunction

    function automatic fix_t sat_add(input fix_t a, input fix_t b);
        return fit_fix(wide_t'(a) + wide_t'(b));
    endfunction

    // v*v rescaled to 2.16: keep the sign bit and product bits 32..16.
    function automatic fix_t sq_hi(input fix_t x);
        logic signed [35:0] p;
        p = 36'(x) * 36'(x);
`ifdef IZH_SAT_EN
        if (p[35:33] != {3{p[35]}}) return p[35] ? FIX_MIN : FIX_MAX;
`endif
        return {p[35], p[32:16]};
    endfunction

endpackage

// File: rtl/izh_update_unit.sv
// izh_update_unit: combinational Izhikevich update for one neuron.
// Build option: IZH_SAT_EN (saturating arithmetic via izh_pkg helpers).
module izh_update_unit
    import izh_pkg::*;
(
    input  logic signed [17:0] v,
    input  logic signed [17:0] u,
    input  logic signed [17:0] i,
    input  logic signed [17:0] v_th,
    input  logic signed [17:0] c14,
    input  logic        [3:0]  a_sh,
    input  logic        [3:0]  b_sh,
    input  logic signed [17:0] c,
    input  logic signed [17:0] d,
    output logic signed [17:0] v_n,
    output logic signed [17:0] u_n,
    output logic               spk
);

    fix_t  vv;
    fix_t  inner;
    fix_t  diff;
    wide_t sum_w;

    // Membrane/recovery update; a spike overrides with the reset values.
    always_comb begin
        vv    = sq_hi(v);
        sum_w = wide_t'(vv) + wide_t'(v) + wide_t'(v >>> 2) + wide_t'(c14 >>> 2)
              - wide_t'(u >>> 2) + wide_t'(i >>> 2);
        inner = fit_fix(sum_w);
        diff  = fix_t'((v >>> b_sh) - u);
        spk   = (v > v_th);
        if (spk) begin
            v_n = c;
            u_n = sat_add(u, d);
        end else begin
            v_n = sat_add(v, inner >>> 2);
            u_n = sat_add(u, (diff >>> a_sh) >>> 4);
        end
    end

endmodule

// File: rtl/izh_step_scheduler.sv
// izh_step_scheduler: walks all neurons through one shared update unit per
// timestep (load -> calc -> write-back) and streams out spiking indices.
// Build option: IZH_SAT_EN (saturating datapath arithmetic).
module izh_step_scheduler
    import izh_pkg::*;
#(
    parameter int                 NUM_NEURONS = 16,
    parameter int                 N           = 18,
    parameter logic signed [N-1:0] V_INIT     = 18'sh3_4CCD,
    parameter logic signed [N-1:0] U_INIT     = 18'sh3_CCCD,
    localparam int                IDX_W       = $clog2(NUM_NEURONS)
)(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 step_req,
    output logic                 step_ready,
    output logic                 step_done,
    input  logic signed [N-1:0]  v_th,
    input  logic signed [N-1:0]  c14,
    input  logic        [3:0]    a_sh,
    input  logic        [3:0]    b_sh,
    input  logic signed [N-1:0]  c,
    input  logic signed [N-1:0]  d,
    input  logic                 cur_we,
    input  logic [IDX_W-1:0]     cur_idx,
    input  logic signed [N-1:0]  cur_data,
    input  logic                 init_we,
    input  logic [IDX_W-1:0]     init_idx,
    input  logic signed [N-1:0]  init_v,
    input  logic signed [N-1:0]  init_u,
    output logic                 spike_valid,
    input  logic                 spike_ready,
    output logic [IDX_W-1:0]     spike_idx,
    output logic [IDX_W:0]       spike_count
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             wr_vld_p1;

    fix_t v_mem [NUM_NEURONS];
    fix_t u_mem [NUM_NEURONS];
    fix_t i_mem [NUM_NEURONS];

    fix_t       prm_v_th, prm_c14, prm_c, prm_d;
    logic [3:0] prm_a_sh, prm_b_sh;

    fix_t v_p0, u_p0, i_p0;
    fix_t v_n_p1, u_n_p1;
    fix_t v_n, u_n;
    logic spk;

    izh_update_unit u_update (
        .v    (v_p0),
        .u    (u_p0),
        .i    (i_p0),
        .v_th (prm_v_th),
        .c14  (prm_c14),
        .a_sh (prm_a_sh),
        .b_sh (prm_b_sh),
        .c    (prm_c),
        .d    (prm_d),
        .v_n  (v_n),
        .u_n  (u_n),
        .spk  (spk)
    );

    // Sequencer: step handshake, neuron index, spike stream and done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            idx         <= '0;
            wr_vld_p1   <= 1'b0;
            step_ready  <= 1'b1;
            step_done   <= 1'b0;
            spike_valid <= 1'b0;
            spike_idx   <= '0;
            spike_count <= '0;
        end else begin
            step_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (step_req) begin
                        spike_count <= '0;
                        idx         <= '0;
                        step_ready  <= 1'b0;
                        state       <= S_LOAD;
                    end
                end
                S_LOAD: state <= S_CALC;
                S_CALC: begin
                    wr_vld_p1   <= 1'b1;
                    spike_valid <= spk;
                    if (spk) begin
                        spike_idx   <= idx;
                        spike_count <= spike_count + (IDX_W + 1)'(1);
                    end
                    state <= S_WRITE;
                end
                S_WRITE: begin
                    wr_vld_p1 <= 1'b0;
                    if (!spike_valid || spike_ready) begin
                        spike_valid <= 1'b0;
                        if (idx == LAST_IDX) begin
                            state <= S_DONE;
                        end else begin
                            idx   <= idx + IDX_W'(1);
                            state <= S_LOAD;
                        end
                    end
                end
                S_DONE: begin
                    step_done  <= 1'b1;
                    step_ready <= 1'b1;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Neuron state and current storage: host writes plus single write-back.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NUM_NEURONS; k++) begin
                v_mem[k] <= V_INIT;
                u_mem[k] <= U_INIT;
                i_mem[k] <= '0;
            end
        end else begin
            if (cur_we) i_mem[cur_idx] <= cur_data;
            if (state == S_IDLE && init_we) begin
                v_mem[init_idx] <= init_v;
                u_mem[init_idx] <= init_u;
            end
            if (state == S_WRITE && wr_vld_p1) begin
                v_mem[idx] <= v_n_p1;
                u_mem[idx] <= u_n_p1;
            end
        end
    end

    // Data stages: parameter latch, LOAD operands (_p0), CALC results (_p1).
    always_ff @(posedge clk) begin
        if (state == S_IDLE && step_req) begin
            prm_v_th <= v_th;
            prm_c14  <= c14;
            prm_a_sh <= a_sh;
            prm_b_sh <= b_sh;
            prm_c    <= c;
            prm_d    <= d;
        end
        if (state == S_LOAD) begin
            v_p0 <= v_mem[idx];
            u_p0 <= u_mem[idx];
            i_p0 <= i_mem[idx];
        end
        if (state == S_CALC) begin
            v_n_p1 <= v_n;
            u_n_p1 <= u_n;
        end
    end

endmodule

// File: tb/tb_izh_step_scheduler.sv
// tb_izh_step_scheduler: directed and randomized timesteps checked against an
// integer reference model of the neuron update. Honors IZH_SAT_EN.
module tb_izh_step_scheduler;

    localparam int NN = 16;
    localparam int IW = 4;
    localparam logic signed [17:0] VI = 18'sh3_4CCD;
    localparam logic signed [17:0] UI = 18'sh3_CCCD;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic step_req = 1'b0;
    logic step_ready, step_done;
    logic signed [17:0] v_th = 18'sh1_FFFF, c14 = '0, c = '0, d = '0;
    logic [3:0] a_sh = 4'd1, b_sh = 4'd2;
    logic cur_we = 1'b0;
    logic [IW-1:0] cur_idx = '0;
    logic signed [17:0] cur_data = '0;
    logic init_we = 1'b0;
    logic [IW-1:0] init_idx = '0;
    logic signed [17:0] init_v = '0, init_u = '0;
    logic spike_valid;
    logic spike_ready = 1'b0;
    logic [IW-1:0] spike_idx;
    logic [IW:0] spike_count;

    always #5 clk = ~clk;

    izh_step_scheduler dut (
        .clk(clk), .reset(reset), .step_req(step_req), .step_ready(step_ready),
        .step_done(step_done), .v_th(v_th), .c14(c14), .a_sh(a_sh), .b_sh(b_sh),
        .c(c), .d(d), .cur_we(cur_we), .cur_idx(cur_idx), .cur_data(cur_data),
        .init_we(init_we), .init_idx(init_idx), .init_v(init_v), .init_u(init_u),
        .spike_valid(spike_valid), .spike_ready(spike_ready), .spike_idx(spike_idx),
        .spike_count(spike_count)
    );

    longint mv[NN], mu[NN], mi[NN];
    int exp_spk[$];
    int got_spk[$];
    int n_chk = 0, n_pass = 0;
    int last_done;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Clip (saturating build) or wrap into the signed 18-bit range.
    function automatic longint fit(input longint x);
`ifdef IZH_SAT_EN
        if (x > 131071) return 131071;
        if (x < -131072) return -131072;
        return x;
`else
        return ((x + 131072) % 262144 + 262144) % 262144 - 131072;
`endif
    endfunction

    function automatic longint wrap18(input longint x);
        return ((x + 131072) % 262144 + 262144) % 262144 - 131072;
    endfunction

    // v^2 in 2.16: floor(v*v / 2^16), limited to 17 magnitude bits.
    function automatic longint vv_of(input longint v);
        longint hi;
        hi = (v * v) / 65536;
`ifdef IZH_SAT_EN
        return (hi > 131071) ? 131071 : hi;
`else
        return hi % 131072;
`endif
    endfunction

    function automatic longint fdiv(input longint x, input int sh);
        longint q;
        q = x / (longint'(1) << sh);
        if (x < 0 && q * (longint'(1) << sh) != x) q = q - 1;
        return q;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < NN; k++) begin
            mv[k] = VI; mu[k] = UI; mi[k] = 0;
        end
    endfunction

    function automatic void model_step();
        longint vt, cq, v, u, i, inner, dif;
        vt = v_th; cq = c14;
        exp_spk.delete();
        for (int k = 0; k < NN; k++) begin
            v = mv[k]; u = mu[k]; i = mi[k];
            if (v > vt) begin
                exp_spk.push_back(k);
                mv[k] = c;
                mu[k] = fit(u + longint'(d));
            end else begin
                inner = fit(vv_of(v) + v + fdiv(v, 2) + fdiv(cq, 2) - fdiv(u, 2) + fdiv(i, 2));
                mv[k] = fit(v + fdiv(inner, 2));
                dif = wrap18(fdiv(v, int'(b_sh)) - u);
                mu[k] = fit(u + fdiv(dif, int'(a_sh) + 4));
            end
        end
    endfunction

    task automatic preload(input int k, input logic signed [17:0] v, input logic signed [17:0] u);
        init_we = 1'b1; init_idx = IW'(k); init_v = v; init_u = u;
        @(negedge clk);
        init_we = 1'b0;
        mv[k] = v; mu[k] = u;
    endtask

    task automatic wcur(input int k, input logic signed [17:0] x);
        cur_we = 1'b1; cur_idx = IW'(k); cur_data = x;
        @(negedge clk);
        cur_we = 1'b0;
        mi[k] = x;
    endtask

    task automatic check_arrays(input string tag);
        for (int k = 0; k < NN; k++) begin
            chk({tag, "_v"}, dut.v_mem[k], mv[k]);
            chk({tag, "_u"}, dut.u_mem[k], mu[k]);
        end
    endtask

    // One timestep. stall_n < 0: random backpressure; else ready low stall_n cycles per spike.
    task automatic run_step(input int stall_n, input bit poke, input string tag);
        int n, stalls, done_at, hold_cnt, held;
        bit was_stall;
        logic signed [17:0] px0, px15;
        px0 = 18'($urandom); px15 = 18'($urandom);
        if (poke) mi[15] = px15;
        model_step();
        if (poke) mi[0] = px0;
        got_spk.delete();
        n = 0; stalls = 0; done_at = -1; hold_cnt = 0; held = 0; was_stall = 1'b0;
        step_req = 1'b1;
        @(negedge clk);
        step_req = 1'b0;
        while (n < 600 && done_at < 0) begin
            cur_we = 1'b0; init_we = 1'b0; step_req = 1'b0;
            if (poke && n == 0) begin cur_we = 1'b1; cur_idx = 0; cur_data = px0; end
            if (poke && n == 1) begin cur_we = 1'b1; cur_idx = 15; cur_data = px15; end
            if (poke && n == 6) begin
                step_req = 1'b1; init_we = 1'b1; init_idx = 3; init_v = 18'sh1_0000; init_u = '0;
            end
            if (was_stall) begin
                chk({tag, "_hold_valid"}, spike_valid, 1);
                chk({tag, "_hold_idx"}, spike_idx, held);
            end
            was_stall = 1'b0;
            if (spike_valid) begin
                if (stall_n < 0) spike_ready = ($urandom_range(0, 2) != 0);
                else begin
                    spike_ready = (hold_cnt >= stall_n);
                    hold_cnt = spike_ready ? 0 : hold_cnt + 1;
                end
                if (!spike_ready) begin
                    stalls++; was_stall = 1'b1; held = int'(spike_idx);
                end else got_spk.push_back(int'(spike_idx));
            end else spike_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            n++;
            if (step_done) done_at = n;
        end
        cur_we = 1'b0; init_we = 1'b0; step_req = 1'b0; spike_ready = 1'b0;
        chk({tag, "_done_seen"}, done_at >= 0, 1);
        chk({tag, "_done_cycle"}, done_at, 3 * NN + 1 + stalls);
        chk({tag, "_ready"}, step_ready, 1);
        chk({tag, "_count"}, spike_count, exp_spk.size());
        chk({tag, "_nspikes"}, got_spk.size(), exp_spk.size());
        for (int s = 0; s < exp_spk.size() && s < got_spk.size(); s++)
            chk({tag, "_order"}, got_spk[s], exp_spk[s]);
        check_arrays(tag);
        @(negedge clk);
        chk({tag, "_done_pulse"}, step_done, 0);
        last_done = done_at;
    endtask

    task automatic rand_step(input string tag);
        v_th = 18'($urandom); c14 = 18'($urandom); c = 18'($urandom); d = 18'($urandom);
        a_sh = 4'($urandom); b_sh = 4'($urandom_range(0, 3));
        for (int j = 0; j < 5; j++) preload($urandom_range(0, NN - 1), 18'($urandom), 18'($urandom));
        for (int j = 0; j < 4; j++) wcur($urandom_range(0, NN - 1), 18'($urandom));
        run_step(-1, 1'b0, tag);
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_ready", step_ready, 1);
        chk("rst_done", step_done, 0);
        chk("rst_valid", spike_valid, 0);
        chk("rst_idx", spike_idx, 0);
        chk("rst_count", spike_count, 0);
        reset = 1'b0;

        // Reset state read back through a spike-free step.
        v_th = 18'sh1_FFFF; c14 = 18'sh0_8000; a_sh = 4'd1; b_sh = 4'd2;
        run_step(0, 1'b0, "reset_step");

        // Single spike on neuron 5.
        preload(5, 18'sh0_8000, 18'sh3_CCCD);
        v_th = 18'sh0_4CCC; c = 18'sh3_8000; d = 18'sh0_051E;
        run_step(0, 1'b0, "spike");
        chk("spike_v5", dut.v_mem[5], 18'sh3_8000);
        chk("spike_u5", dut.u_mem[5], 18'sh3_D1EB);
        chk("spike_cnt1", spike_count, 1);

        // Backpressure: neurons 2 and 3 spike, 4 stall cycles each.
        for (int k = 0; k < NN; k++) preload(k, VI, UI);
        preload(2, 18'sh0_8000, UI);
        preload(3, 18'sh0_8000, UI);
        run_step(4, 1'b0, "bp");
        chk("bp_latency", last_done, 3 * NN + 1 + 8);

        // Mid-step step_req/init_we ignored; current writes around LOAD of idx 0/15.
        run_step(-1, 1'b1, "ignore");
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("ignore_no_second_done", step_done, 0);
            chk("ignore_stays_idle", step_ready, 1);
        end

        // Overflow corner.
        preload(0, 18'sh1_C000, 18'sh2_0000);
        wcur(0, 18'sh1_FFFF);
        v_th = 18'sh1_FFFF; c14 = '0; a_sh = 4'd0; b_sh = 4'd0;
        run_step(0, 1'b0, "sat");
`ifdef IZH_SAT_EN
        chk("sat_v0_clip", dut.v_mem[0], 18'sh1_FFFF);
`endif

        for (int r = 0; r < 3; r++) rand_step($sformatf("rand%0d", r));

        // Reset while a spike is pending.
        for (int k = 0; k < NN; k++) preload(k, VI, UI);
        preload(1, 18'sh0_8000, UI);
        v_th = 18'sh0_4CCC;
        step_req = 1'b1;
        @(negedge clk);
        step_req = 1'b0; spike_ready = 1'b0;
        for (int t = 0; t < 60 && !spike_valid; t++) @(negedge clk);
        chk("rm_valid_before", spike_valid, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        chk("rm_valid", spike_valid, 0);
        chk("rm_ready", step_ready, 1);
        chk("rm_count", spike_count, 0);
        check_arrays("rm");

        rand_step("post_reset");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
